sm_block_accumulator: RTL and testbench

//  Sequential accumulate stage downstream of the 12-bit sign-magnitude adder datapath.

---
 rtl/sm_block_accumulator_if.sv | 21 ++
 rtl/sm_block_accumulator.sv | 117 +++++++++++
 tb/tb_sm_block_accumulator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sm_block_accumulator_if.sv
// Sample-in / block-sum-out handshake bundle for the sign-magnitude block accumulator.
// The master drives samples and takes sums; the slave is the accumulator itself.
interface sm_block_accumulator_if;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic        out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/sm_block_accumulator.sv
// Sums COUNT sign-magnitude samples per block using sign-magnitude add rules
// and presents the block sum, with a sticky overflow flag, on a valid/ready output.
module sm_block_accumulator #(
   parameter int COUNT    = 8,
   parameter int SATURATE = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   sm_block_accumulator_if.slave       bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

   state_t      state_q;
   logic [11:0] acc_q;
   logic [7:0]  cnt_q;
   logic        ovf_q;
   logic        outValid_q;

   logic [11:0] magWide;
   logic [10:0] sumMag_d;
   logic        sumSign_d;
   logic        sumOvf_d;
   logic [11:0] sum_d;
   logic        accept;

   // acc is zero in IDLE, so the first sample also goes through the adder,
   // which folds an incoming -0 into +0.
   always_comb begin
      magWide   = {1'b0, acc_q[10:0]} + {1'b0, bus.in_data[10:0]};
      sumMag_d  = 11'd0;
      sumSign_d = 1'b0;
      sumOvf_d  = 1'b0;
      if (acc_q[11] == bus.in_data[11]) begin
         sumSign_d = acc_q[11];
         sumOvf_d  = magWide[11];
         if (magWide[11] && (SATURATE != 0)) begin
            sumMag_d = 11'h7FF;
         end else begin
            sumMag_d = magWide[10:0];
         end
      end else if (acc_q[10:0] >= bus.in_data[10:0]) begin
         sumSign_d = acc_q[11];
         sumMag_d  = acc_q[10:0] - bus.in_data[10:0];
      end else begin
         sumSign_d = bus.in_data[11];
         sumMag_d  = bus.in_data[10:0] - acc_q[10:0];
      end
      if (sumMag_d == 11'd0) begin
         sumSign_d = 1'b0;
      end
   end

   assign sum_d  = {sumSign_d, sumMag_d};
   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= 12'd0;
         cnt_q      <= 8'd0;
         ovf_q      <= 1'b0;
         outValid_q <= 1'b0;
      end else if (clear) begin
         state_q    <= IDLE;
         acc_q      <= 12'd0;
         cnt_q      <= 8'd0;
         ovf_q      <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_q <= sum_d;
                  cnt_q <= cnt_q + 8'd1;
                  ovf_q <= ovf_q | sumOvf_d;
                  if (cnt_q == LAST_CNT) begin
                     state_q    <= HOLD;
                     outValid_q <= 1'b1;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_q    <= IDLE;
                  acc_q      <= 12'd0;
                  cnt_q      <= 8'd0;
                  ovf_q      <= 1'b0;
                  outValid_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               acc_q      <= 12'd0;
               cnt_q      <= 8'd0;
               ovf_q      <= 1'b0;
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q != HOLD) && !clear;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = acc_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_sm_block_accumulator.sv
// Directed bench for sm_block_accumulator across three parameterisations
// sharing one clock, reset and clear.
module tb_sm_block_accumulator;

   logic clk;
   logic rst_n;
   logic clear;

   int compared   = 0;
   int mismatched = 0;

   sm_block_accumulator_if ifA ();
   sm_block_accumulator_if ifB ();
   sm_block_accumulator_if ifC ();

   sm_block_accumulator #(.COUNT(4), .SATURATE(1)) dutA (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifA.slave)
   );
   sm_block_accumulator #(.COUNT(2), .SATURATE(1)) dutB (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifB.slave)
   );
   sm_block_accumulator #(.COUNT(2), .SATURATE(0)) dutC (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifC.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic v, input logic [11:0] d, input logic r);
      case (sel)
         0: begin ifA.in_valid = v; ifA.in_data = d; ifA.out_ready = r; end
         1: begin ifB.in_valid = v; ifB.in_data = d; ifB.out_ready = r; end
         default: begin ifC.in_valid = v; ifC.in_data = d; ifC.out_ready = r; end
      endcase
   endtask

   // One sample presented for exactly one clock edge; consecutive calls are back-to-back.
   task automatic applyStimulus(input int sel, input logic [11:0] d);
      drive(sel, 1'b1, d, 1'b0);
      step();
      drive(sel, 1'b0, 12'h000, 1'b0);
   endtask

   task automatic handshake(input int sel);
      drive(sel, 1'b0, 12'h000, 1'b1);
      step();
      drive(sel, 1'b0, 12'h000, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      drive(0, 1'b0, 12'h000, 1'b0);
      drive(1, 1'b0, 12'h000, 1'b0);
      drive(2, 1'b0, 12'h000, 1'b0);
      step();
      step();
      checkOutput("rst_out_valid", {11'd0, ifA.out_valid}, 12'd0);
      checkOutput("rst_out_data",  ifA.out_data,           12'h000);
      checkOutput("rst_out_ovf",   {11'd0, ifA.out_ovf},   12'd0);
      checkOutput("rst_in_ready",  {11'd0, ifA.in_ready},  12'd1);
      rst_n = 1'b1;
      step();

      // Basic block of four mixed-sign samples
      applyStimulus(0, 12'h005);
      applyStimulus(0, 12'h803);
      applyStimulus(0, 12'h00A);
      checkOutput("t1_valid_before_last", {11'd0, ifA.out_valid}, 12'd0);
      applyStimulus(0, 12'h802);
      checkOutput("t1_valid",    {11'd0, ifA.out_valid}, 12'd1);
      checkOutput("t1_data",     ifA.out_data,           12'h00A);
      checkOutput("t1_ovf",      {11'd0, ifA.out_ovf},   12'd0);
      checkOutput("t1_in_ready", {11'd0, ifA.in_ready},  12'd0);
      handshake(0);
      checkOutput("t1_valid_after_hs",    {11'd0, ifA.out_valid}, 12'd0);
      checkOutput("t1_in_ready_after_hs", {11'd0, ifA.in_ready},  12'd1);

      // Cancellation and negative zero, COUNT=2
      applyStimulus(1, 12'h007);
      applyStimulus(1, 12'h807);
      checkOutput("t2_cancel_valid", {11'd0, ifB.out_valid}, 12'd1);
      checkOutput("t2_cancel_data",  ifB.out_data,           12'h000);
      handshake(1);
      applyStimulus(1, 12'h800);
      applyStimulus(1, 12'h800);
      checkOutput("t2_negzero_data", ifB.out_data, 12'h000);
      handshake(1);
      applyStimulus(1, 12'h005);
      applyStimulus(1, 12'h809);
      checkOutput("t2_larger_sign_data", ifB.out_data, 12'h804);
      handshake(1);

      // Saturation, then backpressure on the saturated result
      applyStimulus(0, 12'h7FF);
      applyStimulus(0, 12'h7FF);
      applyStimulus(0, 12'h7FF);
      applyStimulus(0, 12'h801);
      checkOutput("t3_sat_valid", {11'd0, ifA.out_valid}, 12'd1);
      checkOutput("t3_sat_data",  ifA.out_data,           12'h7FE);
      checkOutput("t3_sat_ovf",   {11'd0, ifA.out_ovf},   12'd1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b1, 12'h7FF, 1'b0);
         step();
         checkOutput("t4_bp_data",     ifA.out_data,           12'h7FE);
         checkOutput("t4_bp_ovf",      {11'd0, ifA.out_ovf},   12'd1);
         checkOutput("t4_bp_in_ready", {11'd0, ifA.in_ready},  12'd0);
         checkOutput("t4_bp_valid",    {11'd0, ifA.out_valid}, 12'd1);
      end
      drive(0, 1'b1, 12'h7FF, 1'b1);
      step();
      drive(0, 1'b0, 12'h000, 1'b0);
      checkOutput("t4_hs_valid", {11'd0, ifA.out_valid}, 12'd0);
      checkOutput("t4_hs_data",  ifA.out_data,           12'h000);
      checkOutput("t4_hs_ovf",   {11'd0, ifA.out_ovf},   12'd0);
      applyStimulus(0, 12'h010);
      applyStimulus(0, 12'h820);
      applyStimulus(0, 12'h005);
      applyStimulus(0, 12'h001);
      checkOutput("t4_next_block_data", ifA.out_data,         12'h80A);
      checkOutput("t4_next_block_ovf",  {11'd0, ifA.out_ovf}, 12'd0);
      handshake(0);

      // Wrap mode, COUNT=2
      applyStimulus(2, 12'h7FF);
      applyStimulus(2, 12'h001);
      checkOutput("t3_wrap_valid", {11'd0, ifC.out_valid}, 12'd1);
      checkOutput("t3_wrap_data",  ifC.out_data,           12'h000);
      checkOutput("t3_wrap_ovf",   {11'd0, ifC.out_ovf},   12'd1);
      handshake(2);
      applyStimulus(2, 12'h805);
      applyStimulus(2, 12'h803);
      checkOutput("t3_wrap_neg_data", ifC.out_data,         12'h808);
      checkOutput("t3_wrap_neg_ovf",  {11'd0, ifC.out_ovf}, 12'd0);
      handshake(2);

      // Gaps in in_valid: idle cycles carry junk data that must not be counted
      applyStimulus(0, 12'h064);
      drive(0, 1'b0, 12'h7FF, 1'b0); step();
      applyStimulus(0, 12'h832);
      drive(0, 1'b0, 12'h7FF, 1'b0); step();
      applyStimulus(0, 12'h019);
      drive(0, 1'b0, 12'h7FF, 1'b0); step();
      checkOutput("t5_valid_before_last", {11'd0, ifA.out_valid}, 12'd0);
      applyStimulus(0, 12'h80A);
      checkOutput("t5_valid", {11'd0, ifA.out_valid}, 12'd1);
      checkOutput("t5_data",  ifA.out_data,           12'h041);
      handshake(0);

      // clear after two samples aborts the block
      applyStimulus(0, 12'h100);
      applyStimulus(0, 12'h100);
      clear = 1'b1;
      drive(0, 1'b1, 12'h555, 1'b0);
      #1;
      checkOutput("t6_clear_in_ready", {11'd0, ifA.in_ready}, 12'd0);
      step();
      clear = 1'b0;
      drive(0, 1'b0, 12'h000, 1'b0);
      checkOutput("t6_clear_valid", {11'd0, ifA.out_valid}, 12'd0);
      checkOutput("t6_clear_data",  ifA.out_data,           12'h000);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h002);
      applyStimulus(0, 12'h003);
      checkOutput("t6_after_clear_early", {11'd0, ifA.out_valid}, 12'd0);
      applyStimulus(0, 12'h004);
      checkOutput("t6_after_clear_data", ifA.out_data, 12'h00A);
      handshake(0);

      // Asynchronous reset mid-block
      applyStimulus(0, 12'h200);
      applyStimulus(0, 12'h200);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_async_data", ifA.out_data, 12'h000);
      step();
      rst_n = 1'b1;
      checkOutput("t6_rst_valid", {11'd0, ifA.out_valid}, 12'd0);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h001);
      checkOutput("t6_after_rst_valid", {11'd0, ifA.out_valid}, 12'd1);
      checkOutput("t6_after_rst_data",  ifA.out_data,           12'h004);

      // clear together with out_ready in HOLD drops the sum
      clear = 1'b1;
      drive(0, 1'b0, 12'h000, 1'b1);
      step();
      clear = 1'b0;
      drive(0, 1'b0, 12'h000, 1'b0);
      checkOutput("t6_hold_clear_valid", {11'd0, ifA.out_valid}, 12'd0);
      checkOutput("t6_hold_clear_data",  ifA.out_data,           12'h000);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h001);
      applyStimulus(0, 12'h801);
      checkOutput("t6_fresh_data", ifA.out_data, 12'h002);
      handshake(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
